inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage directly upstream of the decoder and the client of the instruction cache's dual read ports (X/Y). Each cycle it presents a fetch address pair (pc, pc+4) to the cache. One cycle later it takes 0, 1 or 2 hit instructions and pushes them into an in-order instruction queue. It handles redirects from the branch/commit logic by flushing the queue and restarting at the new PC.

## Interface
Parameters:
- RESET_PC, 32'h0, fetch PC after reset.
- QUEUE_WIDTH, 3, log2 of the instruction queue depth.
- QUEUE_DEPTH, 2**QUEUE_WIDTH, number of queue entries (8).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global ready; when low, all state is held.
- en_rx  out  1  cache port X enable; 1 whenever rst=0.
- pcx  out  32  cache port X address; combinational, equals next_pc.
- hitx  in  1  registered X hit for the previous cycle's pcx.
- instx  in  32  X instruction, valid when hitx=1.
- en_ry  out  1  cache port Y enable; 1 whenever rst=0.
- pcy  out  32  next_pc + 4.
- hity  in  1  registered Y hit.
- insty  in  32  Y instruction.
- jump_en  in  1  redirect request.
- jump_pc  in  32  redirect target; bits [1:0] are forced to 0.
- inst_valid  out  1  queue head is valid.
- inst_out  out  32  queue head instruction.
- inst_pc  out  32  queue head PC.
- inst_ready  in  1  decoder accepts the head this cycle.

## Operation
- State:
  - fetch_pc (32): address whose cache result arrives this cycle.
  - Queue arrays iq_inst, iq_pc[QUEUE_DEPTH].
  - head, tail (QUEUE_WIDTH bits, natural wrap).
  - count (QUEUE_WIDTH+1 bits).
- free = QUEUE_DEPTH - count, computed from registered count. A pop in the same cycle does not free a slot until the next cycle.
- acc_x = hitx && free >= 1.
- acc_y = acc_x && hity && free >= 2. A Y hit behind an X miss is always discarded.
- next_pc:
  - jump_en: {jump_pc[31:2], 2'b00}.
  - Otherwise: fetch_pc + 4*(acc_x + acc_y), where the increment is 0, 4 or 8.
  - Arithmetic is 32-bit modulo.
- Cache timing: pcx = next_pc is sampled by the cache at the edge, and fetch_pc <= next_pc at the same edge. The hitx/hity seen next cycle therefore always belong to fetch_pc. No tag compare is needed.
- Push: acc_x writes (instx, fetch_pc) at tail. acc_y also writes (insty, fetch_pc+4) at tail+1. tail advances by acc_x + acc_y.
- Pop: inst_valid && inst_ready advances head by 1.
- count <= count + pushes - pop.
- inst_valid = (count != 0). inst_out/inst_pc = entry at head. All three are combinational from registers.
- Redirect (jump_en=1) has priority over everything:
  - head, tail and count are cleared.
  - Pushes and the pop in that cycle are discarded.
  - fetch_pc <= jump target.
  - The decoder must ignore inst_valid in the jump cycle.
- Miss on X: fetch_pc is held and pcx is re-presented every cycle until the cache fills and reports hitx.
- rdy=0: no register changes and no push or pop. pcx/pcy continue to present next_pc computed with acc_x = acc_y = 0.

## Timing
- Reset values (rst=1):
  - fetch_pc = RESET_PC; head = tail = count = 0.
  - inst_valid = 0; inst_out = 0; inst_pc = 0.
  - en_rx = en_ry = 0.
  - pcx = RESET_PC; pcy = RESET_PC + 4.
- Fetch latency: address presented in cycle t, hit data in cycle t+1, pushed at the end of t+1. The instruction is visible on inst_out in cycle t+2 when the queue was empty.
- Peak throughput is 2 instructions/cycle in and 1/cycle out.
- Redirect: jump_en asserted in cycle t puts jump_pc on pcx in cycle t. The queue is empty in t+1. The first target instruction is on inst_out in t+2 on a cache hit.
- Full queue (count = QUEUE_DEPTH): no push and fetch_pc holds. With free = 1, only the X instruction is accepted.
- Reset mid-operation discards the queue contents and any response in flight.

## Test plan
- Reset, RESET_PC=0, cache model always hits with inst = address:
  - inst_valid=0 in reset.
  - First cycle after release: pcx=0, pcy=4.
  - inst_out sequence 0, 4, 8, 12…; fetch_pc advances by 8 per cycle until full.
- inst_ready=0, always hit:
  - count saturates at 8 with the last pushed PC = 28.
  - On the cycle with free=1, only X is pushed (no Y).
  - pcx holds at 32.
- X misses at 0x40 for 5 cycles while Y hits:
  - No pushes and pcx=0x40 throughout.
  - After hitx, 0x40 and 0x44 are pushed in the same cycle.
- Queue holding 5 entries, jump_en with jump_pc=0x103:
  - Next cycle: count=0 and pcx=0x108 or 0x104 per hit.
  - First instruction out has inst_pc=0x100.
  - The pop in the jump cycle does not change count.
- rdy=0 for 3 cycles with ready=1 and hits asserted:
  - head, tail, count and fetch_pc are unchanged.
  - Operation resumes with no duplicated or lost PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch: drives a dual-port I-cache with (pc, pc+4) and queues the
// 0/1/2 hit instructions returned one cycle later for the decoder.
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int unsigned QUEUE_WIDTH = 3,
  parameter int unsigned QUEUE_DEPTH = 2**QUEUE_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        en_rx,
  output logic [31:0] pcx,
  input  logic        hitx,
  input  logic [31:0] instx,
  output logic        en_ry,
  output logic [31:0] pcy,
  input  logic        hity,
  input  logic [31:0] insty,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CW = QUEUE_WIDTH + 1;

  logic [31:0]            r_fetch_pc;
  logic [31:0]            r_iq_inst [QUEUE_DEPTH];
  logic [31:0]            r_iq_pc   [QUEUE_DEPTH];
  logic [QUEUE_WIDTH-1:0] r_head;
  logic [QUEUE_WIDTH-1:0] r_tail;
  logic [CW-1:0]          r_count;

  logic                   w_run;
  logic [CW-1:0]          w_free;
  logic                   w_acc_x;
  logic                   w_acc_y;
  logic [1:0]             w_inc;
  logic                   w_push_x;
  logic                   w_push_y;
  logic                   w_pop;
  logic [31:0]            w_next_pc;
  logic [QUEUE_WIDTH-1:0] w_tail_p1;

  assign w_run  = rdy && !rst;
  assign w_free = CW'(QUEUE_DEPTH) - r_count;

  // Y is only taken behind an accepted X so the queue stays in program order.
  assign w_acc_x = w_run && hitx && (w_free >= CW'(1));
  assign w_acc_y = w_acc_x && hity && (w_free >= CW'(2));
  assign w_inc   = {1'b0, w_acc_x} + {1'b0, w_acc_y};

  assign w_push_x = w_acc_x && !jump_en;
  assign w_push_y = w_acc_y && !jump_en;
  assign w_pop    = w_run && !jump_en && inst_ready && (r_count != CW'(0));

  // The cache samples this address at the same edge fetch_pc takes it, so a
  // response always belongs to the current fetch_pc.
  always_comb begin
    w_next_pc = r_fetch_pc + (32'(w_inc) << 2);
    if (rst) begin
      w_next_pc = RESET_PC;
    end else if (jump_en) begin
      w_next_pc = {jump_pc[31:2], 2'b00};
    end
  end

  assign w_tail_p1 = r_tail + QUEUE_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (rdy) begin
      r_fetch_pc <= w_next_pc;
      if (jump_en) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + QUEUE_WIDTH'(w_pop);
        r_tail  <= r_tail + QUEUE_WIDTH'(w_inc);
        r_count <= r_count + CW'(w_inc) - CW'(w_pop);
      end
    end
  end

  // Queue storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push_x) begin
      r_iq_inst[r_tail] <= instx;
      r_iq_pc[r_tail]   <= r_fetch_pc;
    end
    if (w_push_y) begin
      r_iq_inst[w_tail_p1] <= insty;
      r_iq_pc[w_tail_p1]   <= r_fetch_pc + 32'd4;
    end
  end

  assign en_rx = !rst;
  assign en_ry = !rst;
  assign pcx   = w_next_pc;
  assign pcy   = w_next_pc + 32'd4;

  assign inst_valid = (r_count != CW'(0));
  assign inst_out   = inst_valid ? r_iq_inst[r_head] : 32'h0;
  assign inst_pc    = inst_valid ? r_iq_pc[r_head]   : 32'h0;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-cycle cache model returning inst = address.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        en_rx;
  logic [31:0] pcx;
  logic        hitx;
  logic [31:0] instx;
  logic        en_ry;
  logic [31:0] pcy;
  logic        hity;
  logic [31:0] insty;
  logic        jump_en;
  logic [31:0] jump_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        hx_en;
  logic        hy_en;

  int checks   = 0;
  int failures = 0;

  inst_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .en_rx      (en_rx),
    .pcx        (pcx),
    .hitx       (hitx),
    .instx      (instx),
    .en_ry      (en_ry),
    .pcy        (pcy),
    .hity       (hity),
    .insty      (insty),
    .jump_en    (jump_en),
    .jump_pc    (jump_pc),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  // Cache: registered hit and data for the address presented last cycle.
  always @(posedge clk) begin
    hitx  <= !rst && hx_en;
    hity  <= !rst && hy_en;
    instx <= pcx;
    insty <= pcy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; inst_ready = 1'b0; jump_en = 1'b0; jump_pc = 32'h0;
    hx_en = 1'b1; hy_en = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_out",   inst_out, 32'h0);
    chk("rst_pc",    inst_pc, 32'h0);
    chk("rst_enrx",  32'(en_rx), 32'h0);
    chk("rst_enry",  32'(en_ry), 32'h0);
    chk("rst_pcx",   pcx, 32'h0);
    chk("rst_pcy",   pcy, 32'h4);

    // Streaming with all hits
    rst = 1'b0; #1;
    chk("t1_pcx0", pcx, 32'h0);
    chk("t1_pcy0", pcy, 32'h4);
    chk("t1_enrx", 32'(en_rx), 32'h1);
    chk("t1_enry", 32'(en_ry), 32'h1);
    @(negedge clk); inst_ready = 1'b1; #1;
    chk("t1_pcx1", pcx, 32'h8);
    chk("t1_valid1", 32'(inst_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t1_valid", 32'(inst_valid), 32'h1);
      chk("t1_out", inst_out, 32'(4 * i));
      chk("t1_ipc", inst_pc, 32'(4 * i));
      chk("t1_pcx", pcx, 32'(16 + 8 * i));
    end

    // Fill to full with decoder stalled, then a free=1 cycle
    rst = 1'b1; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1; chk("t2_pcx_n4", pcx, 32'd32);
    @(negedge clk); #1;
    chk("t2_full_valid", 32'(inst_valid), 32'h1);
    chk("t2_full_pcx", pcx, 32'd32);
    chk("t2_head_pc", inst_pc, 32'd0);
    @(negedge clk); #1;
    chk("t2_hold_pcx", pcx, 32'd32);
    inst_ready = 1'b1;
    @(negedge clk); inst_ready = 1'b0; #1;
    chk("t2_xonly_pcx", pcx, 32'd36);
    chk("t2_xonly_head", inst_pc, 32'd4);
    @(negedge clk); #1;
    chk("t2_full2_pcx", pcx, 32'd36);
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t2_drain_valid", 32'(inst_valid), 32'h1);
      chk("t2_drain_pc", inst_pc, 32'(4 + 4 * i));
      chk("t2_drain_out", inst_out, 32'(4 + 4 * i));
      @(negedge clk);
    end

    // X miss at 0x40 while Y hits
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; jump_en = 1'b1; jump_pc = 32'h40; hx_en = 1'b0; #1;
    chk("t3_jump_pcx", pcx, 32'h40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); jump_en = 1'b0; #1;
      chk("t3_miss_pcx", pcx, 32'h40);
      chk("t3_miss_valid", 32'(inst_valid), 32'h0);
    end
    hx_en = 1'b1;
    @(negedge clk); #1;
    chk("t3_hit_pcx", pcx, 32'h48);
    chk("t3_hit_valid", 32'(inst_valid), 32'h0);
    @(negedge clk); #1;
    chk("t3_first_valid", 32'(inst_valid), 32'h1);
    chk("t3_first_pc", inst_pc, 32'h40);
    chk("t3_first_out", inst_out, 32'h40);
    @(negedge clk); #1;
    chk("t3_second_pc", inst_pc, 32'h44);
    chk("t3_second_out", inst_out, 32'h44);

    // Redirect with five queued entries
    rst = 1'b1; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk); hy_en = 1'b0; #1;
    chk("t4_pcx16", pcx, 32'd16);
    @(negedge clk); hy_en = 1'b1; #1;
    chk("t4_xonly_pcx", pcx, 32'd20);
    @(negedge clk); #1;
    chk("t4_pre_valid", 32'(inst_valid), 32'h1);
    chk("t4_pre_pc", inst_pc, 32'h0);
    jump_en = 1'b1; jump_pc = 32'h103; inst_ready = 1'b1; #1;
    chk("t4_jump_pcx", pcx, 32'h100);
    chk("t4_jump_pcy", pcy, 32'h104);
    @(negedge clk); jump_en = 1'b0; #1;
    chk("t4_flush_valid", 32'(inst_valid), 32'h0);
    chk("t4_flush_pcx", pcx, 32'h108);
    @(negedge clk); #1;
    chk("t4_tgt_valid", 32'(inst_valid), 32'h1);
    chk("t4_tgt_pc", inst_pc, 32'h100);
    @(negedge clk); #1;
    chk("t4_tgt2_pc", inst_pc, 32'h104);

    // Global stall for three cycles
    rdy = 1'b0; #1;
    chk("t5_stall_pcx", pcx, 32'h110);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("t5_stall_pcx", pcx, 32'h110);
      chk("t5_stall_pc", inst_pc, 32'h104);
      chk("t5_stall_valid", 32'(inst_valid), 32'h1);
    end
    @(negedge clk); rdy = 1'b1; #1;
    chk("t5_resume_pcx", pcx, 32'h118);
    for (int i = 0; i < 8; i++) begin
      chk("t5_seq_valid", 32'(inst_valid), 32'h1);
      chk("t5_seq_pc", inst_pc, 32'(32'h104 + 4 * i));
      @(negedge clk); #1;
    end

    // Reset mid-operation discards the queue
    rst = 1'b1;
    @(negedge clk); #1;
    chk("t6_rst_valid", 32'(inst_valid), 32'h0);
    chk("t6_rst_pcx", pcx, 32'h0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("t6_post_valid", 32'(inst_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
